// File: rtl/svreal_alu.sv
// Fixed-point "real number" ALU: mantissa/exponent operands aligned to a result exponent,
// with a signed comparator, one registered cycle of latency.
module svreal_alu #(
   parameter int unsigned A_WIDTH = 16,
   parameter int unsigned B_WIDTH = 16,
   parameter int unsigned C_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic signed [A_WIDTH-1:0] a_value,
   input  logic signed [31:0]        a_exponent,
   input  logic signed [B_WIDTH-1:0] b_value,
   input  logic signed [31:0]        b_exponent,
   input  logic signed [31:0]        c_exponent,
   input  logic        [2:0]         op,
   input  logic        [2:0]         cmp_op,
   input  logic                      in_valid,
   output logic signed [C_WIDTH-1:0] c_value,
   output logic                      cmp,
   output logic                      out_valid
);

   localparam int unsigned PW = A_WIDTH + B_WIDTH;
   localparam int unsigned WW = ((PW > C_WIDTH) ? PW : C_WIDTH) + 64;
   localparam int unsigned SW = 36;

   localparam logic [2:0] OP_MUL  = 3'd0;
   localparam logic [2:0] OP_ADD  = 3'd1;
   localparam logic [2:0] OP_SUB  = 3'd2;
   localparam logic [2:0] OP_NEG  = 3'd3;
   localparam logic [2:0] OP_MIN  = 3'd4;
   localparam logic [2:0] OP_MAX  = 3'd5;
   localparam logic [2:0] OP_PASS = 3'd6;

   // Shift by s = es - et; positive shifts left, negative shifts right with floor.
   function automatic logic signed [WW-1:0] align_f(input logic signed [WW-1:0] v,
                                                    input logic signed [SW-1:0] s);
      logic signed [SW-1:0] neg;
      neg = -s;
      if (s >= 0) begin
         if (s >= SW'(64)) return '0;
         return v <<< s[5:0];
      end
      if (neg >= SW'(64)) return {WW{v[WW-1]}};
      return v >>> neg[5:0];
   endfunction

   logic signed [31:0]        e_max;
   logic signed [A_WIDTH-1:0] a_cmp;
   logic signed [B_WIDTH-1:0] b_cmp;
   logic signed [C_WIDTH-1:0] a_al, b_al, p_al;
   logic signed [PW-1:0]      prod;
   logic                      b_lt_a, b_gt_a;

   logic signed [C_WIDTH-1:0] c_value_d, c_value_q;
   logic                      cmp_d, cmp_q;
   logic                      out_valid_d, out_valid_q;

   // Comparison operands share the larger exponent so only right shifts occur.
   always_comb begin
      e_max  = (a_exponent > b_exponent) ? a_exponent : b_exponent;
      a_cmp  = A_WIDTH'(align_f(WW'(a_value), SW'(a_exponent) - SW'(e_max)));
      b_cmp  = B_WIDTH'(align_f(WW'(b_value), SW'(b_exponent) - SW'(e_max)));
      b_lt_a = WW'(b_cmp) < WW'(a_cmp);
      b_gt_a = WW'(b_cmp) > WW'(a_cmp);
   end

   always_comb begin
      a_al = C_WIDTH'(align_f(WW'(a_value), SW'(a_exponent) - SW'(c_exponent)));
      b_al = C_WIDTH'(align_f(WW'(b_value), SW'(b_exponent) - SW'(c_exponent)));
      prod = PW'(a_value) * PW'(b_value);
      p_al = C_WIDTH'(align_f(WW'(prod),
                              SW'(a_exponent) + SW'(b_exponent) - SW'(c_exponent)));
   end

   // Result/comparison select; outputs hold while no operation is presented.
   always_comb begin
      c_value_d   = c_value_q;
      cmp_d       = cmp_q;
      out_valid_d = 1'b0;
      if (in_valid) begin
         out_valid_d = 1'b1;
         case (op)
            OP_MUL:  c_value_d = p_al;
            OP_ADD:  c_value_d = a_al + b_al;
            OP_SUB:  c_value_d = a_al - b_al;
            OP_NEG:  c_value_d = -a_al;
            OP_MIN:  c_value_d = b_lt_a ? b_al : a_al;
            OP_MAX:  c_value_d = b_gt_a ? b_al : a_al;
            OP_PASS: c_value_d = a_al;
            default: c_value_d = '0;
         endcase
         case (cmp_op)
            3'd0:    cmp_d = b_lt_a;
            3'd1:    cmp_d = !b_gt_a;
            3'd2:    cmp_d = b_gt_a;
            3'd3:    cmp_d = !b_lt_a;
            3'd4:    cmp_d = !b_lt_a && !b_gt_a;
            3'd5:    cmp_d = b_lt_a || b_gt_a;
            default: cmp_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_value_q   <= '0;
         cmp_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         c_value_q   <= c_value_d;
         cmp_q       <= cmp_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign c_value   = c_value_q;
   assign cmp       = cmp_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_svreal_alu.sv
// Directed bench for svreal_alu: expectations queued at drive time, popped one cycle later.
module tb_svreal_alu;

   typedef struct {
      int   c;
      logic cmp;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst_n;
   logic signed [15:0] a_value, b_value;
   logic signed [31:0] a_exponent, b_exponent, c_exponent;
   logic        [2:0]  op, cmp_op;
   logic               in_valid;
   logic signed [15:0] c_value;
   logic               cmp, out_valid;
   logic signed [7:0]  c8;
   logic               cmp8, ov8;

   exp_t sb[$];
   exp_t sb8[$];
   int   checks   = 0;
   int   failures = 0;

   svreal_alu #(.A_WIDTH(16), .B_WIDTH(16), .C_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_value(a_value), .a_exponent(a_exponent),
      .b_value(b_value), .b_exponent(b_exponent),
      .c_exponent(c_exponent), .op(op), .cmp_op(cmp_op), .in_valid(in_valid),
      .c_value(c_value), .cmp(cmp), .out_valid(out_valid)
   );

   svreal_alu #(.A_WIDTH(16), .B_WIDTH(16), .C_WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .a_value(a_value), .a_exponent(a_exponent),
      .b_value(b_value), .b_exponent(b_exponent),
      .c_exponent(c_exponent), .op(op), .cmp_op(cmp_op), .in_valid(in_valid),
      .c_value(c8), .cmp(cmp8), .out_valid(ov8)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic [2:0] op_i, input logic [2:0] cmp_i,
                       input int av, input int ae, input int bv, input int be, input int ce,
                       input int exp_c, input logic exp_cmp);
      exp_t e;
      @(negedge clk);
      a_value    = 16'(av);
      a_exponent = ae;
      b_value    = 16'(bv);
      b_exponent = be;
      c_exponent = ce;
      op         = op_i;
      cmp_op     = cmp_i;
      in_valid   = 1'b1;
      sb.push_back('{exp_c, exp_cmp});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({tag, "_valid"}, 32'(out_valid), 32'(1));
      check({tag, "_c"}, 32'(c_value), e.c);
      check({tag, "_cmp"}, 32'(cmp), 32'(e.cmp));
   endtask

   initial begin
      exp_t e8;
      rst_n = 1'b0; in_valid = 1'b0; op = '0; cmp_op = '0;
      a_value = '0; b_value = '0; a_exponent = '0; b_exponent = '0; c_exponent = '0;
      #1;
      check("rst_c", 32'(c_value), 32'(0));
      check("rst_cmp", 32'(cmp), 32'(0));
      check("rst_valid", 32'(out_valid), 32'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_valid", 32'(out_valid), 32'(0));
      check("post_rst_c", 32'(c_value), 32'(0));

      // 1.5 (384 @ -8) and 2.25 (36 @ -4), result exponent -8
      step("add",  3'd1, 3'd0, 384, -8, 36, -4, -8, 960, 1'b0);
      step("sub",  3'd2, 3'd2, 384, -8, 36, -4, -8, -192, 1'b1);
      step("mul",  3'd0, 3'd5, 384, -8, 36, -4, -8, 864, 1'b1);
      step("neg",  3'd3, 3'd4, 384, -8, 36, -4, -8, -384, 1'b0);
      step("min",  3'd4, 3'd1, 384, -8, 36, -4, -8, 384, 1'b0);
      step("max",  3'd5, 3'd3, 384, -8, 36, -4, -8, 576, 1'b1);
      step("pass", 3'd6, 3'd6, 384, -8, 36, -4, -8, 384, 1'b0);
      step("op7",  3'd7, 3'd7, 384, -8, 36, -4, -8, 0, 1'b0);
      step("floor_m1",  3'd6, 3'd2, -1, -8, 0, 0, -4, -1, 1'b1);
      step("floor_15",  3'd6, 3'd4, 15, -8, 0, 0, -4, 0, 1'b1);
      step("lshift_64", 3'd6, 3'd5, 5, 0, 0, 0, -70, 0, 1'b1);
      step("rshift_64", 3'd6, 3'd3, -5, 0, 0, 0, 100, -1, 1'b1);
      step("mul_neg",   3'd0, 3'd4, -3, 0, 5, 0, 0, -15, 1'b0);

      sb8.push_back('{-56, 1'b1});
      step("wrap16", 3'd1, 3'd1, 100, 0, 100, 0, 0, 200, 1'b1);
      e8 = sb8.pop_front();
      check("wrap8_valid", 32'(ov8), 32'(1));
      check("wrap8_c", 32'(c8), e8.c);
      check("wrap8_cmp", 32'(cmp8), 32'(e8.cmp));

      step("min_b", 3'd4, 3'd0, 384, -8, 16, -4, -8, 256, 1'b1);

      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("idle_valid", 32'(out_valid), 32'(0));
      check("idle_c_hold", 32'(c_value), 32'(256));
      check("idle_cmp_hold", 32'(cmp), 32'(1));

      // Reset lands between edges while an operation is pending; it must be dropped
      @(negedge clk);
      a_value = 16'(384); a_exponent = -8; b_value = 16'(36); b_exponent = -4;
      c_exponent = -8; op = 3'd1; cmp_op = 3'd2; in_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_c", 32'(c_value), 32'(0));
      check("midrst_cmp", 32'(cmp), 32'(0));
      check("midrst_valid", 32'(out_valid), 32'(0));
      @(posedge clk);
      #1;
      check("midrst_hold_c", 32'(c_value), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("rel_valid", 32'(out_valid), 32'(0));
      check("rel_c", 32'(c_value), 32'(0));

      step("add_after_rst", 3'd1, 3'd2, 384, -8, 36, -4, -8, 960, 1'b1);

      @(negedge clk);
      in_valid = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
